mem_port_b_arbiter: RTL and testbench

// - Shares the read-only second port (address_b/read_data_b) of memory_stage between NUM_REQ

---
 rtl/mem_port_b_arbiter_pkg.sv | 36 +++
 rtl/mem_port_b_arbiter_if.sv | 34 +++
 rtl/mem_port_b_arbiter_rr_priority_picker.sv | 44 ++++
 rtl/mem_port_b_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_b_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_b_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared widths, types and helpers for the memory port B arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 24;
    localparam int ID_W   = 3;

    typedef logic [ADDR_W-1:0] mem_addr_t;
    typedef logic [DATA_W-1:0] mem_word_t;

    // One slot of the in-flight return pipe: who is owed the word.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } inflight_t;

    // Encode a one-hot vector (up to 8 requesters) into a requester index.
    // The OR-accumulation is exact for one-hot input and zero for no grant.
    function automatic logic [ID_W-1:0] onehot_to_id(input logic [7:0] onehot);
        logic [ID_W-1:0] v_id;
        v_id = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                v_id = v_id | ID_W'(i);
            end
        end
        return v_id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_b_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_b_arbiter_if
// Brief    : Requester / memory port B bundle for the port B arbiter.
//            slave  = arbiter side, master = requesters plus the RAM port.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_b_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        gnt;
    mem_addr_t                 address_b;
    mem_word_t                 read_data_b;
    logic [NUM_REQ-1:0]        rvalid;
    mem_word_t                 rdata;
    logic                      busy;

    modport slave (
        input  req, req_addr, lock, read_data_b,
        output gnt, address_b, rvalid, rdata, busy
    );

    modport master (
        output req, req_addr, lock, read_data_b,
        input  gnt, address_b, rvalid, rdata, busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_b_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Rotate requests so the pointer index is bit 0, pick the lowest
//            set bit, rotate the one-hot result back. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [NUM_REQ-1:0] w_rot_req;
    logic [NUM_REQ-1:0] w_rot_gnt;

    // Rotate right by ptr: rotated bit j is requester (ptr + j) mod NUM_REQ.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        w_rot_req = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            v_idx        = PTR_W'((int'(ptr) + j) % NUM_REQ);
            w_rot_req[j] = req[v_idx];
        end
    end

    // Lowest set bit of the rotated vector wins.
    assign w_rot_gnt = w_rot_req & (~w_rot_req + NUM_REQ'(1));

    // Rotate the winner back into requester numbering.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        gnt = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            v_idx      = PTR_W'((int'(ptr) + j) % NUM_REQ);
            gnt[v_idx] = w_rot_gnt[j];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_b_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_b_arbiter
// Brief    : Round-robin arbiter sharing the read-only port B of memory_stage
//            between NUM_REQ requesters. One read issued per cycle, data
//            returned to its owner READ_LATENCY+1 cycles after the grant.
//            Optional grant locking is built when MEM_ARB_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_b_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int READ_LATENCY = 1,
    parameter int MAX_LOCK     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_b_arbiter_if.slave  bus
);

    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [c_ptr_w-1:0] r_ptr;
    logic [NUM_REQ-1:0] w_pick;
    logic [NUM_REQ-1:0] w_gnt_raw;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_grant_any;
    logic [ID_W-1:0]    w_gnt_id;
    mem_addr_t          w_gnt_addr;
    mem_addr_t          r_address_b;
    inflight_t          r_pipe [READ_LATENCY+1];

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_picker (
        .req (bus.req),
        .ptr (r_ptr),
        .gnt (w_pick)
    );

`ifdef MEM_ARB_LOCK_EN
    localparam int c_cnt_w = $clog2(MAX_LOCK + 1);

    logic [NUM_REQ-1:0] r_prev_gnt;
    logic [c_cnt_w-1:0] r_lock_cnt;
    logic               w_hold;

    // The previous holder keeps the port while it locks and has budget left.
    assign w_hold    = (|(r_prev_gnt & bus.req & bus.lock)) &&
                       (r_lock_cnt < c_cnt_w'(MAX_LOCK - 1));
    assign w_gnt_raw = w_hold ? r_prev_gnt : w_pick;

    // Track the last holder and how many re-grants it has consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev_gnt <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_prev_gnt <= w_gnt;
            if (w_hold) begin
                r_lock_cnt <= r_lock_cnt + c_cnt_w'(1);
            end else begin
                r_lock_cnt <= '0;
            end
        end
    end
`else
    logic w_unused_lock;

    assign w_gnt_raw     = w_pick;
    assign w_unused_lock = ^{bus.lock, 32'(MAX_LOCK)};
`endif

    // No grant may leak out while reset is asserted.
    assign w_gnt       = rst ? w_gnt_raw : '0;
    assign w_grant_any = |w_gnt;
    assign w_gnt_id    = onehot_to_id(8'(w_gnt));

    // Select the winning requester's address.
    always_comb begin
        w_gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Issue the read, advance the RR pointer and shift the return pipe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_address_b <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= inflight_t'({w_grant_any, w_gnt_id});
            for (int i = 1; i <= READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            if (w_grant_any) begin
                r_address_b <= w_gnt_addr;
                if (w_gnt_id == ID_W'(NUM_REQ - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= c_ptr_w'(w_gnt_id + ID_W'(1));
                end
            end
        end
    end

    // The last pipe stage lines up with read_data_b; decode its owner.
    always_comb begin
        bus.rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rvalid[i] = r_pipe[READ_LATENCY].valid &&
                            (r_pipe[READ_LATENCY].id == ID_W'(i));
        end
    end

    // Busy whenever any issued read has not yet returned.
    always_comb begin
        bus.busy = 1'b0;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            bus.busy = bus.busy | r_pipe[i].valid;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.address_b = r_address_b;
    assign bus.rdata     = (|bus.rvalid) ? bus.read_data_b : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_b_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_b_arbiter
// Brief    : Self-checking bench for mem_port_b_arbiter with a 1-cycle RAM
//            model, NUM_REQ=2, READ_LATENCY=1, MAX_LOCK=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_b_arbiter;
    import mem_arb_pkg::*;

    localparam int NUM_REQ  = 2;
    localparam int RL       = 1;
    localparam int MAX_LOCK = 4;

    typedef struct {
        int        id;
        mem_addr_t addr;
        int        due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    exp_t      sb_q [$];
    int        m_ptr  = 0;
    mem_addr_t m_addr = '0;
    int        m_prev = -1;
    int        m_cnt  = 0;

    mem_port_b_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_if ();

    mem_port_b_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .READ_LATENCY (RL),
        .MAX_LOCK     (MAX_LOCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic mem_word_t ram_word(input mem_addr_t a);
        return {a[5:0], a} ^ 24'hA5C396;
    endfunction

    // RAM port B: address registered on the edge, data one cycle later.
    always @(posedge clk) bus_if.read_data_b <= ram_word(bus_if.address_b);

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin : mon
        int        eg;
        int        hold;
        int        idx;
        mem_addr_t a;
        if (chk_en) begin
            check_value("busy", 32'(bus_if.busy), 32'(sb_q.size() != 0));
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                check_value("rvalid", 32'(bus_if.rvalid), 32'(1) << sb_q[0].id);
                check_value("rdata", 32'(bus_if.rdata), 32'(ram_word(sb_q[0].addr)));
                void'(sb_q.pop_front());
            end else begin
                check_value("rvalid_idle", 32'(bus_if.rvalid), 32'd0);
            end
            check_value("address_b", 32'(bus_if.address_b), 32'(m_addr));

            eg   = -1;
            hold = 0;
            if (rst) begin
`ifdef MEM_ARB_LOCK_EN
                if (m_prev >= 0 && bus_if.req[m_prev] && bus_if.lock[m_prev] && m_cnt < MAX_LOCK - 1) begin
                    eg   = m_prev;
                    hold = 1;
                end
`endif
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (eg < 0 && bus_if.req[idx]) eg = idx;
                end
            end
            check_value("gnt", 32'(bus_if.gnt), (eg < 0) ? 32'd0 : (32'(1) << eg));

            if (!rst) begin
                sb_q.delete();
                m_ptr  = 0;
                m_addr = '0;
                m_prev = -1;
                m_cnt  = 0;
            end else begin
                if (eg >= 0) begin
                    a = bus_if.req_addr[eg*ADDR_W +: ADDR_W];
                    sb_q.push_back('{eg, a, cyc + 1 + RL});
                    m_ptr  = (eg + 1) % NUM_REQ;
                    m_addr = a;
                    m_cnt  = hold ? m_cnt + 1 : 0;
                end else begin
                    m_cnt = 0;
                end
                m_prev = eg;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int                 lock_seq [6];
        logic [NUM_REQ-1:0] g;
`ifdef MEM_ARB_LOCK_EN
        lock_seq = '{1, 1, 1, 1, 2, 1};
`else
        lock_seq = '{1, 2, 1, 2, 1, 2};
`endif
        bus_if.req      = 2'b11;
        bus_if.req_addr = {18'h00200, 18'h00100};
        bus_if.lock     = '0;
        rst             = 1'b0;

        // Reset held for three edges with both requesters asking.
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check_value("rst_gnt", 32'(bus_if.gnt), 32'd0);
        check_value("rst_rvalid", 32'(bus_if.rvalid), 32'd0);
        check_value("rst_address_b", 32'(bus_if.address_b), 32'd0);
        check_value("rst_busy", 32'(bus_if.busy), 32'd0);
        tick();
        rst        = 1'b1;
        bus_if.req = '0;
        tick();

        // Single read from requester 0.
        bus_if.req             = 2'b01;
        bus_if.req_addr[17:0]  = 18'h00010;
        @(negedge clk);
        check_value("single_gnt", 32'(bus_if.gnt), 32'd1);
        tick();
        bus_if.req = '0;
        @(negedge clk);
        check_value("single_addr", 32'(bus_if.address_b), 32'h10);
        tick();
        @(negedge clk);
        check_value("single_rvalid", 32'(bus_if.rvalid), 32'd1);
        check_value("single_rdata", 32'(bus_if.rdata), 32'(ram_word(18'h00010)));

        // Top address from requester 1, then idle cycles hold address_b.
        tick();
        bus_if.req             = 2'b10;
        bus_if.req_addr[35:18] = 18'h3FFFF;
        @(negedge clk);
        check_value("top_gnt", 32'(bus_if.gnt), 32'd2);
        tick();
        bus_if.req = '0;
        @(negedge clk);
        check_value("top_addr", 32'(bus_if.address_b), 32'h3FFFF);
        tick();
        @(negedge clk);
        check_value("top_rvalid", 32'(bus_if.rvalid), 32'd2);
        check_value("top_rdata", 32'(bus_if.rdata), 32'(ram_word(18'h3FFFF)));
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check_value("idle_addr", 32'(bus_if.address_b), 32'h3FFFF);
        end

        // Contention: both requesters continuously for four cycles.
        tick();
        bus_if.req      = 2'b11;
        bus_if.req_addr = {18'h00200, 18'h00100};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_value("cont_gnt", 32'(bus_if.gnt), (i % 2 != 0) ? 32'd2 : 32'd1);
            tick();
        end
        bus_if.req = '0;
        repeat (3) tick();

        // Requester 0 locks while both request.
        bus_if.req  = 2'b11;
        bus_if.lock = 2'b01;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_value("lock_gnt", 32'(bus_if.gnt), 32'(lock_seq[i]));
            tick();
        end
        bus_if.req  = '0;
        bus_if.lock = '0;
        repeat (3) tick();

        // Reset arrives the cycle after a grant: the return is dropped.
        bus_if.req            = 2'b01;
        bus_if.req_addr[17:0] = 18'h00055;
        @(negedge clk);
        check_value("mf_gnt", 32'(bus_if.gnt), 32'd1);
        tick();
        bus_if.req = '0;
        rst        = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_value("mf_rvalid", 32'(bus_if.rvalid), 32'd0);
        check_value("mf_busy", 32'(bus_if.busy), 32'd0);

        // Random traffic; a request is held with its address until granted.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            g = bus_if.gnt;
            tick();
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!bus_if.req[r] || g[r]) begin
                    bus_if.req[r]                      = ($urandom_range(0, 3) != 0);
                    bus_if.req_addr[r*ADDR_W +: ADDR_W] = 18'($urandom);
                    bus_if.lock[r]                     = 1'($urandom_range(0, 1));
                end
            end
        end
        bus_if.req  = '0;
        bus_if.lock = '0;
        repeat (5) tick();
        @(negedge clk);
        check_value("drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
